// File: rtl/cell_link_packet_arbiter.sv
// Packet-aware round-robin arbiter: two first-word-fallthrough AXI-stream sources share one output stream.
// Grants change only at packet boundaries, and a stall watchdog frees a grant held by a source that has died.
module cell_link_packet_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int STALL_TIMEOUT = 255,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  S00_AXIS_TVALID,
    output logic                  S00_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] S00_AXIS_TDATA,
    input  logic                  S00_AXIS_TLAST,
    input  logic                  S01_AXIS_TVALID,
    output logic                  S01_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] S01_AXIS_TDATA,
    input  logic                  S01_AXIS_TLAST,
    input  logic                  S00_ARB_REQ_SUPPRESS,
    input  logic                  S01_ARB_REQ_SUPPRESS,
    output logic                  M00_AXIS_TVALID,
    input  logic                  M00_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M00_AXIS_TDATA,
    output logic                  M00_AXIS_TLAST,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  pkt_count0,
    output logic [CNT_WIDTH-1:0]  pkt_count1,
    output logic                  stall_err,
    input  logic                  clear
);

    localparam int SCW = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic [SCW-1:0]       stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] pkt_count0_q, pkt_count0_d;
    logic [CNT_WIDTH-1:0] pkt_count1_q, pkt_count1_d;
    logic                 stall_err_q, stall_err_d;

    logic elig0, elig1;
    logic pkt_end, stall_hit;

    assign elig0 = S00_AXIS_TVALID & ~S00_ARB_REQ_SUPPRESS;
    assign elig1 = S01_AXIS_TVALID & ~S01_ARB_REQ_SUPPRESS;

    assign pkt_end   = M00_AXIS_TVALID & M00_AXIS_TREADY & M00_AXIS_TLAST;
    // Only an absent word counts toward the watchdog; downstream backpressure never does.
    assign stall_hit = (state_q == BUSY) & ~M00_AXIS_TVALID
                     & (stall_cnt_q == SCW'(STALL_TIMEOUT - 1));

    assign grant      = grant_q;
    assign pkt_count0 = pkt_count0_q;
    assign pkt_count1 = pkt_count1_q;
    assign stall_err  = stall_err_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            rr_ptr_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (elig0 && (!elig1 || !rr_ptr_q)) begin
                    state_d = BUSY;
                    grant_d = 2'b01;
                end else if (elig1) begin
                    state_d = BUSY;
                    grant_d = 2'b10;
                end
            end
            BUSY: begin
                if (pkt_end || stall_hit) begin
                    state_d  = IDLE;
                    grant_d  = 2'b00;
                    rr_ptr_d = grant_q[0];
                end else if (!M00_AXIS_TVALID) begin
                    stall_cnt_d = stall_cnt_q + SCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Datapath is a pure mux of the granted source; idle output is forced to zero.
    always_comb begin
        M00_AXIS_TVALID = 1'b0;
        M00_AXIS_TDATA  = '0;
        M00_AXIS_TLAST  = 1'b0;
        S00_AXIS_TREADY = 1'b0;
        S01_AXIS_TREADY = 1'b0;
        if (grant_q[0]) begin
            M00_AXIS_TVALID = S00_AXIS_TVALID;
            M00_AXIS_TDATA  = S00_AXIS_TDATA;
            M00_AXIS_TLAST  = S00_AXIS_TLAST;
            S00_AXIS_TREADY = M00_AXIS_TREADY;
        end else if (grant_q[1]) begin
            M00_AXIS_TVALID = S01_AXIS_TVALID;
            M00_AXIS_TDATA  = S01_AXIS_TDATA;
            M00_AXIS_TLAST  = S01_AXIS_TLAST;
            S01_AXIS_TREADY = M00_AXIS_TREADY;
        end
    end

    always_comb begin
        pkt_count0_d = pkt_count0_q;
        pkt_count1_d = pkt_count1_q;
        stall_err_d  = stall_err_q;
        if (clear) begin
            pkt_count0_d = '0;
            pkt_count1_d = '0;
            stall_err_d  = 1'b0;
        end else begin
            if (pkt_end && grant_q[0]) pkt_count0_d = pkt_count0_q + CNT_WIDTH'(1);
            if (pkt_end && grant_q[1]) pkt_count1_d = pkt_count1_q + CNT_WIDTH'(1);
            if (stall_hit)             stall_err_d  = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pkt_count0_q <= '0;
            pkt_count1_q <= '0;
            stall_err_q  <= 1'b0;
        end else begin
            pkt_count0_q <= pkt_count0_d;
            pkt_count1_q <= pkt_count1_d;
            stall_err_q  <= stall_err_d;
        end
    end

endmodule

// File: tb/tb_cell_link_packet_arbiter.sv
// Scoreboard bench for cell_link_packet_arbiter: source FIFOs modelled as queues, expected output order
// queued when packets are offered and compared word by word as M00 handshakes occur.
module tb_cell_link_packet_arbiter;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          s00_tvalid, s00_tready, s00_tlast;
    logic [DW-1:0] s00_tdata;
    logic          s01_tvalid, s01_tready, s01_tlast;
    logic [DW-1:0] s01_tdata;
    logic          s00_sup, s01_sup;
    logic          m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [1:0]    grant;
    logic [CW-1:0] cnt0, cnt1;
    logic          stall_err;
    logic          clr;

    int errors = 0;
    int checks = 0;
    int n;
    bit tog = 1'b0;

    logic [32:0] src0_q[$];
    logic [32:0] src1_q[$];
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    cell_link_packet_arbiter #(
        .DATA_WIDTH(DW), .STALL_TIMEOUT(TO), .CNT_WIDTH(CW)
    ) dut (
        .ACLK(clk), .ARESETN(arst_n),
        .S00_AXIS_TVALID(s00_tvalid), .S00_AXIS_TREADY(s00_tready),
        .S00_AXIS_TDATA(s00_tdata), .S00_AXIS_TLAST(s00_tlast),
        .S01_AXIS_TVALID(s01_tvalid), .S01_AXIS_TREADY(s01_tready),
        .S01_AXIS_TDATA(s01_tdata), .S01_AXIS_TLAST(s01_tlast),
        .S00_ARB_REQ_SUPPRESS(s00_sup), .S01_ARB_REQ_SUPPRESS(s01_sup),
        .M00_AXIS_TVALID(m_tvalid), .M00_AXIS_TREADY(m_tready),
        .M00_AXIS_TDATA(m_tdata), .M00_AXIS_TLAST(m_tlast),
        .grant(grant), .pkt_count0(cnt0), .pkt_count1(cnt1),
        .stall_err(stall_err), .clear(clr)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive_srcs();
        s00_tvalid = src0_q.size() > 0;
        s00_tdata  = (src0_q.size() > 0) ? src0_q[0][31:0] : '0;
        s00_tlast  = (src0_q.size() > 0) ? src0_q[0][32] : 1'b0;
        s01_tvalid = src1_q.size() > 0;
        s01_tdata  = (src1_q.size() > 0) ? src1_q[0][31:0] : '0;
        s01_tlast  = (src1_q.size() > 0) ? src1_q[0][32] : 1'b0;
    endtask

    task automatic push_pkt(input int src, input logic [31:0] base, input int len,
                            input int nwords, input bit to_src, input bit to_sb);
        logic [32:0] w;
        for (int i = 0; i < nwords; i++) begin
            w = {(i == len - 1), base + 32'(i)};
            if (to_src) begin
                if (src == 0) src0_q.push_back(w);
                else          src1_q.push_back(w);
            end
            if (to_sb) sb.push_back(w);
        end
    endtask

    // One clock: sample/compare on the falling edge, advance sources just after the rising edge.
    task automatic step();
        bit hs0, hs1;
        logic [32:0] exp;
        @(negedge clk);
        hs0 = s00_tvalid && s00_tready;
        hs1 = s01_tvalid && s01_tready;
        if (m_tvalid && m_tready) begin
            chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk("m_word", {m_tlast, m_tdata}, exp);
            end
        end
        @(posedge clk);
        #1;
        if (hs0 && src0_q.size() > 0) void'(src0_q.pop_front());
        if (hs1 && src1_q.size() > 0) void'(src1_q.pop_front());
        if (tog) m_tready = ~m_tready;
        drive_srcs();
    endtask

    task automatic run_until_empty(input int budget, output int steps);
        steps = 0;
        while (sb.size() > 0 && steps < budget) begin
            step();
            steps++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        src0_q.delete();
        src1_q.delete();
        sb.delete();
        clr      = 1'b0;
        s00_sup  = 1'b0;
        s01_sup  = 1'b0;
        m_tready = 1'b1;
        tog      = 1'b0;
        drive_srcs();
        step();
        step();
        arst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        arst_n = 1'b0;
        clr = 1'b0; s00_sup = 1'b0; s01_sup = 1'b0; m_tready = 1'b1;
        drive_srcs();
        do_reset();
        step();
        chk("rst_grant", grant, 2'b00);
        chk("rst_mvalid", m_tvalid, 1'b0);
        chk("rst_tready0", s00_tready, 1'b0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_stall_err", stall_err, 1'b0);

        // Single source, 5-word packet.
        push_pkt(0, 32'hA0, 5, 5, 1, 1);
        drive_srcs();
        chk("t1_grant_before", grant, 2'b00);
        step();
        chk("t1_grant", grant, 2'b01);
        run_until_empty(50, n);
        chk("t1_beats", n, 5);
        chk("t1_idle_after", grant, 2'b00);
        chk("t1_cnt0", cnt0, 1);

        // Both sources busy: strict alternation with turnaround.
        do_reset();
        push_pkt(0, 32'hB0, 5, 5, 1, 1);
        push_pkt(1, 32'hC0, 5, 5, 1, 1);
        push_pkt(0, 32'hB8, 5, 5, 1, 1);
        push_pkt(1, 32'hC8, 5, 5, 1, 1);
        for (int i = 0; i < 5; i++) src0_q.delete(5 + i);
        src0_q.delete();
        src1_q.delete();
        push_pkt(0, 32'hB0, 5, 5, 1, 0);
        push_pkt(0, 32'hB8, 5, 5, 1, 0);
        push_pkt(1, 32'hC0, 5, 5, 1, 0);
        push_pkt(1, 32'hC8, 5, 5, 1, 0);
        drive_srcs();
        run_until_empty(100, n);
        chk("t2_cycles", n, 24);
        chk("t2_cnt0", cnt0, 2);
        chk("t2_cnt1", cnt1, 2);

        // Suppress holds source 1 off; releasing it in IDLE lets rr_ptr pick it.
        s01_sup = 1'b1;
        push_pkt(0, 32'hD0, 5, 5, 1, 1);
        push_pkt(0, 32'hD8, 5, 5, 1, 1);
        push_pkt(1, 32'hE0, 5, 5, 1, 0);
        drive_srcs();
        run_until_empty(100, n);
        chk("t3_idle_suppressed", grant, 2'b00);
        chk("t3_tready1", s01_tready, 1'b0);
        push_pkt(1, 32'hE0, 5, 5, 0, 1);
        push_pkt(0, 32'hF0, 5, 5, 1, 1);
        s01_sup = 1'b0;
        drive_srcs();
        step();
        chk("t3_grant_s01", grant, 2'b10);
        run_until_empty(100, n);
        chk("t3_cnt0", cnt0, 5);
        chk("t3_cnt1", cnt1, 3);

        // Source 0 dies after two words; watchdog abandons after TO idle cycles.
        do_reset();
        push_pkt(0, 32'h60, 5, 2, 1, 1);
        push_pkt(1, 32'h70, 5, 5, 1, 0);
        drive_srcs();
        run_until_empty(50, n);
        chk("t4_words_before_stall", n, 3);
        repeat (TO - 1) step();
        chk("t4_grant_held", grant, 2'b01);
        chk("t4_no_err_yet", stall_err, 1'b0);
        step();
        chk("t4_grant_dropped", grant, 2'b00);
        chk("t4_stall_err", stall_err, 1'b1);
        chk("t4_cnt0", cnt0, 0);
        push_pkt(1, 32'h70, 5, 5, 0, 1);
        step();
        chk("t4_grant_s01", grant, 2'b10);
        run_until_empty(50, n);
        chk("t4_cnt1", cnt1, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t4_clr_err", stall_err, 1'b0);
        chk("t4_clr_cnt0", cnt0, 0);
        chk("t4_clr_cnt1", cnt1, 0);

        // Downstream ready toggling every cycle.
        push_pkt(0, 32'h80, 5, 5, 1, 1);
        m_tready = 1'b1;
        tog = 1'b1;
        drive_srcs();
        step();
        run_until_empty(50, n);
        tog = 1'b0;
        m_tready = 1'b1;
        chk("t5_cycles", n, 10);
        chk("t5_stall_err", stall_err, 1'b0);
        chk("t5_cnt0", cnt0, 1);

        // Asynchronous reset in the middle of a packet.
        push_pkt(0, 32'h90, 5, 5, 1, 0);
        push_pkt(0, 32'h90, 5, 3, 0, 1);
        drive_srcs();
        run_until_empty(50, n);
        chk("t6_pre_rst_valid", m_tvalid, 1'b1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("t6_rst_tready0", s00_tready, 1'b0);
        chk("t6_rst_mvalid", m_tvalid, 1'b0);
        chk("t6_rst_grant", grant, 2'b00);
        do_reset();
        push_pkt(0, 32'h40, 5, 5, 1, 1);
        push_pkt(1, 32'h50, 5, 5, 1, 1);
        drive_srcs();
        step();
        chk("t6_grant_s00", grant, 2'b01);
        run_until_empty(100, n);
        chk("t6_cnt0", cnt0, 1);
        chk("t6_cnt1", cnt1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cell_link_packet_arbiter.md
Name: cell_link_packet_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one cell-link forwarding output stream between two AXI-stream sources.
- The sources are first-word-fallthrough FIFOs carrying 32-bit cell-link packets delimited by TLAST.
- Grants are issued only at packet boundaries, honour per-source arbitration-suppress inputs, and are released by a stall watchdog if a source dies mid-packet.
- Per-source packet counters are provided for status readback.

Parameters:
- DATA_WIDTH, 32, stream data width.
- STALL_TIMEOUT, 255, consecutive idle cycles (granted TVALID low) mid-packet before the grant is abandoned; minimum 1.
- CNT_WIDTH, 16, width of per-source packet counters.

Ports:
- ACLK  in  1  sole clock.
- ARESETN  in  1  asynchronous, active-low reset.
- S00_AXIS_TVALID  in  1  source 0 word valid.
- S00_AXIS_TREADY  out  1  source 0 word accepted.
- S00_AXIS_TDATA  in  DATA_WIDTH  source 0 data.
- S00_AXIS_TLAST  in  1  source 0 end of packet.
- S01_AXIS_TVALID/TREADY/TDATA/TLAST  same as S00, for source 1.
- S00_ARB_REQ_SUPPRESS  in  1  source 0 may not win a new grant.
- S01_ARB_REQ_SUPPRESS  in  1  source 1 may not win a new grant.
- M00_AXIS_TVALID  out  1  output valid.
- M00_AXIS_TREADY  in  1  downstream ready.
- M00_AXIS_TDATA  out  DATA_WIDTH  output data.
- M00_AXIS_TLAST  out  1  output end of packet.
- grant  out  2  one-hot current grant; 00 = idle.
- pkt_count0  out  CNT_WIDTH  packets forwarded from source 0.
- pkt_count1  out  CNT_WIDTH  packets forwarded from source 1.
- stall_err  out  1  sticky; a watchdog abandon occurred.
- clear  in  1  synchronous clear of pkt_count0/1 and stall_err.

Behaviour:
- Reset (asynchronous, immediate, may occur mid-packet):
  - state=IDLE, grant=00, rr_ptr=0 (source 0 preferred), stall counter=0, counters=0, stall_err=0.
  - All TREADY=0, M00_AXIS_TVALID=0.
- Eligibility: source i is eligible when Sxx_AXIS_TVALID=1 and Sxx_ARB_REQ_SUPPRESS=0.
- IDLE:
  - If no source is eligible, stay in IDLE.
  - If exactly one source is eligible, grant it.
  - If both are eligible, grant the source selected by rr_ptr.
  - Grant is registered: BUSY and one-hot grant take effect on the next edge, so first-word latency is 1 cycle from TVALID.
- BUSY:
  - Output is combinational from the granted source: M00 TVALID/TDATA/TLAST = granted source; granted TREADY = M00_AXIS_TREADY.
  - Non-granted TREADY=0 at all times.
  - With grant=00, M00_AXIS_TDATA=0 and M00_AXIS_TLAST=0.
- Packet end: on a handshake (M00 TVALID & TREADY) with TLAST=1:
  - increment that source's pkt_count;
  - set rr_ptr to the other source;
  - go to IDLE.
  - There is one mandatory idle turnaround cycle between packets, including repeat grants to the same source.
- Suppress is sampled only in IDLE. Asserting it during BUSY does not interrupt the packet in flight.
- Stall watchdog:
  - In BUSY, the counter increments each cycle the granted TVALID=0 and resets to 0 on any cycle the granted TVALID=1.
  - Downstream backpressure (TVALID=1, TREADY=0) is not a stall.
  - When the counter reaches STALL_TIMEOUT: set stall_err, go to IDLE, set rr_ptr to the other source, no pkt_count increment, no synthetic TLAST emitted.
- Counters wrap modulo 2^CNT_WIDTH.
- clear:
  - Zeroes pkt_count0/1 and stall_err on the next edge.
  - When clear and an increment or stall event occur in the same cycle, clear wins.
  - clear does not affect grant or state.
- Single-word packets (TLAST on the first beat) are legal: BUSY lasts until that one handshake.
- TDATA/TLAST of a source are don't-care while its TVALID=0. Input FIFOs are first-word-fallthrough; this block holds no data storage.

Test Plan:
- Reset, then S00 presents 5-word packet 0xA0..0xA4 with TLAST on 0xA4, M00 TREADY=1 → grant=01 one cycle after TVALID; M00 shows 0xA0..0xA4 back-to-back; pkt_count0=1; grant=00 for one cycle after.
- Both sources continuously offer 5-word packets → output alternates S00, S01, S00, S01 with one idle cycle between packets; after 4 packets pkt_count0=2 and pkt_count1=2.
- S01_ARB_REQ_SUPPRESS=1, both sources valid → only S00 packets forwarded; deassert suppress in IDLE → S01 granted next, since rr_ptr points to it.
- S00 stalls after word 2 of 5 (TVALID low) with STALL_TIMEOUT=8 → after 8 idle cycles grant=00, stall_err=1, pkt_count0 unchanged, S01 then granted if valid; then pulse clear → stall_err=0, counters=0.
- M00 TREADY toggled 1/0 every cycle during a 5-word packet → no word lost or duplicated, stall_err stays 0, packet takes 10 cycles.
- ARESETN asserted mid-packet on word 3 → TREADY and M00 TVALID drop immediately, grant=00; after release, arbitration restarts with source 0 preferred.
